// File: rtl/pcma_coe_loader_if.sv
// Host/compensator-facing bus of pcma_coe_loader; PCMA_COE_READBACK_EN adds the shadow-bank read port.
interface pcma_coe_loader_if #(
    parameter int EQ_LEN    = 19,
    parameter int FCW       = 24,
    parameter int HOLDOFF_W = 10
);
    localparam int AW = (EQ_LEN > 1) ? $clog2(EQ_LEN) : 1;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [FCW-1:0]       wr_data;
    logic                 wr_err;
    logic                 start;
    logic                 with_preset;
    logic                 teach_req;
    logic [HOLDOFF_W-1:0] holdoff;
    logic                 busy;
    logic                 done;
    logic                 preset_coe;
    logic                 load_coe;
    logic [FCW-1:0]       o_init_coe;
    logic                 teach_en;
`ifdef PCMA_COE_READBACK_EN
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic [FCW-1:0]       rd_data;
    logic                 rd_vld;

    modport slave (input wr_en, wr_addr, wr_data, start, with_preset, teach_req, holdoff, rd_en, rd_addr,
                   output wr_err, busy, done, preset_coe, load_coe, o_init_coe, teach_en, rd_data, rd_vld);
    modport master (output wr_en, wr_addr, wr_data, start, with_preset, teach_req, holdoff, rd_en, rd_addr,
                    input wr_err, busy, done, preset_coe, load_coe, o_init_coe, teach_en, rd_data, rd_vld);
`else
    modport slave (input wr_en, wr_addr, wr_data, start, with_preset, teach_req, holdoff,
                   output wr_err, busy, done, preset_coe, load_coe, o_init_coe, teach_en);
    modport master (output wr_en, wr_addr, wr_data, start, with_preset, teach_req, holdoff,
                    input wr_err, busy, done, preset_coe, load_coe, o_init_coe, teach_en);
`endif
endinterface

// File: rtl/pcma_coe_loader.sv
// Shadow coefficient bank replayed into pcma_compensator as load_coe strobes, with teach gating.
// Optional shadow-bank readback port enabled by PCMA_COE_READBACK_EN.
module pcma_coe_loader #(
    parameter int COE_WIDTH     = 16,
    parameter int INV_COE_WIDTH = 8,
    parameter int EQ_LEN        = 19,
    parameter int LOAD_GAP      = 1,
    parameter int HOLDOFF_W     = 10
) (
    input logic               clk,
    input logic               reset_n,
    pcma_coe_loader_if.slave  bus
);
    localparam int FCW = COE_WIDTH + INV_COE_WIDTH;
    localparam int AW  = (EQ_LEN > 1) ? $clog2(EQ_LEN) : 1;
    localparam int GW  = (LOAD_GAP > 0) ? $clog2(LOAD_GAP + 1) : 1;

    typedef enum logic [2:0] {IDLE, PRESET, PGAP, LOAD, FIN} state_t;

    state_t               state, state_next;
    logic [AW-1:0]        idx, idx_next;
    logic [GW-1:0]        gap, gap_next;
    logic [HOLDOFF_W-1:0] hcnt, hcnt_next;
    logic [FCW-1:0]       bank [EQ_LEN];
    logic                 busy_next, strobe_next, wr_ok;

    assign wr_ok = bus.wr_en && !bus.busy && ({1'b0, bus.wr_addr} < (AW+1)'(EQ_LEN));

    // Start is also accepted in FIN, where busy already reads 0.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        gap_next   = gap;
        unique case (state)
            IDLE, FIN: begin
                state_next = IDLE;
                if (bus.start) begin
                    state_next = bus.with_preset ? PRESET : LOAD;
                    idx_next   = '0;
                    gap_next   = '0;
                end
            end
            PRESET: state_next = PGAP;
            PGAP:   state_next = LOAD;
            LOAD: begin
                if (gap != '0) begin
                    gap_next = gap - 1'b1;
                end else if (idx == AW'(EQ_LEN - 1)) begin
                    state_next = FIN;
                end else begin
                    idx_next = idx + 1'b1;
                    gap_next = GW'(LOAD_GAP);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next   = (state_next == PRESET) || (state_next == PGAP) || (state_next == LOAD);
        strobe_next = (state_next == LOAD) && (gap_next == '0);
        hcnt_next   = (state == FIN) ? bus.holdoff : (hcnt != '0) ? hcnt - 1'b1 : hcnt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= '0;
            gap            <= '0;
            hcnt           <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.preset_coe <= 1'b0;
            bus.load_coe   <= 1'b0;
            bus.o_init_coe <= '0;
            bus.teach_en   <= 1'b0;
            bus.wr_err     <= 1'b0;
        end else begin
            state          <= state_next;
            idx            <= idx_next;
            gap            <= gap_next;
            hcnt           <= hcnt_next;
            bus.busy       <= busy_next;
            bus.done       <= (state_next == FIN);
            bus.preset_coe <= (state_next == PRESET);
            bus.load_coe   <= strobe_next;
            if (strobe_next)
                bus.o_init_coe <= bank[idx_next];
            // Teach stays off through FIN and the hold-off window that follows it.
            bus.teach_en   <= bus.teach_req && !busy_next && (state_next != FIN) && (hcnt_next == '0);
            bus.wr_err     <= bus.wr_en && !wr_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < EQ_LEN; i++)
                bank[i] <= '0;
        end else if (wr_ok) begin
            bank[bus.wr_addr] <= bus.wr_data;
        end
    end

`ifdef PCMA_COE_READBACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_vld  <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            bus.rd_vld <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_data <= ({1'b0, bus.rd_addr} < (AW+1)'(EQ_LEN)) ? bank[bus.rd_addr] : '0;
        end
    end
`endif
endmodule
